alu_sequencer: RTL and testbench

Multi-cycle execute sequencer that drives the combinational ALU from the other side of its interface. It accepts one RV32I instruction per handshake, fetches operands from the register file and decodes the immediate. It then generates `op1`/`op2`/`ALU_ctrl`, captures `ALUout`/`eq`, and commits either a register write-back or a branch decision. It sits between instruction fetch, the register file and the ALU in the multi-cycle core.

---
 rtl/alu_pkg.sv | 125 ++++++++++++
 rtl/alu_sequencer_imm_gen.sv | 19 +
 rtl/alu_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and RV32I decode for the multi-cycle execute sequencer.
// The decode helper maps opcode/funct fields to an operand class and ALU op.
package alu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_SLL = 4'b0100,
    ALU_SLT = 4'b0101,
    ALU_SRL = 4'b0110,
    ALU_SRA = 4'b0111,
    ALU_BGE = 4'b1000,
    ALU_XOR = 4'b1001
  } alu_ctrl_t;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    EXEC   = 2'd2,
    COMMIT = 2'd3
  } seq_state_t;

  typedef enum logic [1:0] {
    CLS_ILLEGAL = 2'd0,
    CLS_REG     = 2'd1,
    CLS_IMM     = 2'd2,
    CLS_BRANCH  = 2'd3
  } op_class_t;

  typedef struct packed {
    op_class_t  cls;
    alu_ctrl_t  ctrl;
    logic       wb_flag;    // SLT/SLTI write back the flag, not the result
    logic       use_shamt;
    logic [2:0] funct3;
  } decode_t;

  function automatic decode_t decode_instr(input logic [6:0] opc,
                                           input logic [2:0] f3,
                                           input logic [6:0] f7);
    decode_t d;
    logic    legal;
    logic    base;
    logic    alt;
    base  = (f7 == F7_BASE);
    alt   = (f7 == F7_ALT);
    legal = 1'b0;
    d     = '{cls: CLS_ILLEGAL, ctrl: ALU_ADD, wb_flag: 1'b0, use_shamt: 1'b0, funct3: f3};
    case (opc)
      OP: begin
        d.cls = CLS_REG;
        case (f3)
          F3_ADD: begin legal = base || alt; d.ctrl = alt ? ALU_SUB : ALU_ADD; end
          F3_SLL: begin legal = base; d.ctrl = ALU_SLL; end
          F3_SLT: begin legal = base; d.ctrl = ALU_SLT; d.wb_flag = 1'b1; end
          F3_XOR: begin legal = base; d.ctrl = ALU_XOR; end
          F3_SR:  begin legal = base || alt; d.ctrl = alt ? ALU_SRA : ALU_SRL; end
          F3_OR:  begin legal = base; d.ctrl = ALU_OR; end
          F3_AND: begin legal = base; d.ctrl = ALU_AND; end
          default: legal = 1'b0;
        endcase
      end
      OP_IMM: begin
        d.cls = CLS_IMM;
        case (f3)
          F3_ADD: begin legal = 1'b1; d.ctrl = ALU_ADD; end
          F3_SLT: begin legal = 1'b1; d.ctrl = ALU_SLT; d.wb_flag = 1'b1; end
          F3_XOR: begin legal = 1'b1; d.ctrl = ALU_XOR; end
          F3_OR:  begin legal = 1'b1; d.ctrl = ALU_OR; end
          F3_AND: begin legal = 1'b1; d.ctrl = ALU_AND; end
          F3_SLL: begin legal = base; d.ctrl = ALU_SLL; d.use_shamt = 1'b1; end
          F3_SR:  begin
            legal       = base || alt;
            d.ctrl      = alt ? ALU_SRA : ALU_SRL;
            d.use_shamt = 1'b1;
          end
          default: legal = 1'b0;
        endcase
      end
      BRANCH: begin
        d.cls = CLS_BRANCH;
        case (f3)
          F3_BEQ, F3_BNE: begin legal = 1'b1; d.ctrl = ALU_SUB; end
          F3_BLT:         begin legal = 1'b1; d.ctrl = ALU_SLT; end
          F3_BGE:         begin legal = 1'b1; d.ctrl = ALU_BGE; end
          default:        legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      d.cls       = CLS_ILLEGAL;
      d.ctrl      = ALU_ADD;
      d.wb_flag   = 1'b0;
      d.use_shamt = 1'b0;
    end
    return d;
  endfunction

endpackage

// File: rtl/alu_sequencer_imm_gen.sv
// Combinational immediate extraction: I-type, shift amount and B-type offset.
module imm_gen
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] i_imm_c,
  output logic [XLEN-1:0] sh_imm_c,
  output logic [XLEN-1:0] b_imm_c
);

  logic unused_c;

  assign i_imm_c  = {{20{instr[31]}}, instr[31:20]};
  assign sh_imm_c = {27'd0, instr[24:20]};
  assign b_imm_c  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

  assign unused_c = ^{instr[19:12], instr[6:0]};

endmodule

// File: rtl/alu_sequencer.sv
// Four-state execute sequencer: accept, read operands, drive the ALU, commit.
// Every output is a flop; COMMIT strobes last exactly one cycle.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned Data_Width = 32,
  parameter int unsigned Addr_Width = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [31:0]           instr,
  output logic [Addr_Width-1:0] rs1_addr,
  output logic [Addr_Width-1:0] rs2_addr,
  input  logic [Data_Width-1:0] rs1_data,
  input  logic [Data_Width-1:0] rs2_data,
  output logic [Data_Width-1:0] op1,
  output logic [Data_Width-1:0] op2,
  output logic [3:0]            ALU_ctrl,
  input  logic [Data_Width-1:0] ALUout,
  input  logic                  eq,
  output logic                  rd_we,
  output logic [Addr_Width-1:0] rd_addr,
  output logic [Data_Width-1:0] rd_wdata,
  output logic                  br_valid,
  output logic                  br_taken,
  output logic [Data_Width-1:0] br_offset,
  output logic                  illegal
);

  seq_state_t            state_q, state_d;
  logic                  ready_q, ready_d;
  logic [31:0]           instr_q, instr_d;
  logic [Addr_Width-1:0] rs1_addr_q, rs1_addr_d;
  logic [Addr_Width-1:0] rs2_addr_q, rs2_addr_d;
  op_class_t             cls_q, cls_d;
  logic                  wb_flag_q, wb_flag_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [Data_Width-1:0] br_imm_q, br_imm_d;
  logic [Data_Width-1:0] op1_q, op1_d;
  logic [Data_Width-1:0] op2_q, op2_d;
  alu_ctrl_t             ctrl_q, ctrl_d;
  logic                  rd_we_q, rd_we_d;
  logic [Addr_Width-1:0] rd_addr_q, rd_addr_d;
  logic [Data_Width-1:0] rd_wdata_q, rd_wdata_d;
  logic                  br_valid_q, br_valid_d;
  logic                  br_taken_q, br_taken_d;
  logic [Data_Width-1:0] br_offset_q, br_offset_d;
  logic                  illegal_q, illegal_d;

  decode_t         dec_c;
  logic            accept_c;
  logic [4:0]      rd_c;
  logic [XLEN-1:0] i_imm_c;
  logic [XLEN-1:0] sh_imm_c;
  logic [XLEN-1:0] b_imm_c;

  imm_gen u_imm_gen (
    .instr    (instr_q),
    .i_imm_c  (i_imm_c),
    .sh_imm_c (sh_imm_c),
    .b_imm_c  (b_imm_c)
  );

  assign dec_c    = decode_instr(instr_q[6:0], instr_q[14:12], instr_q[31:25]);
  assign accept_c = instr_valid && ready_q;
  assign rd_c     = instr_q[11:7];

  // Next-state and next-output logic; strobes default low so they last one cycle.
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    rs1_addr_d  = rs1_addr_q;
    rs2_addr_d  = rs2_addr_q;
    cls_d       = cls_q;
    wb_flag_d   = wb_flag_q;
    funct3_d    = funct3_q;
    br_imm_d    = br_imm_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    ctrl_d      = ctrl_q;
    rd_we_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    rd_wdata_d  = rd_wdata_q;
    br_valid_d  = 1'b0;
    br_taken_d  = br_taken_q;
    br_offset_d = br_offset_q;
    illegal_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d    = READ;
          instr_d    = instr;
          rs1_addr_d = Addr_Width'(instr[19:15]);
          rs2_addr_d = Addr_Width'(instr[24:20]);
        end
      end
      READ: begin
        state_d   = EXEC;
        cls_d     = dec_c.cls;
        wb_flag_d = dec_c.wb_flag;
        funct3_d  = dec_c.funct3;
        br_imm_d  = Data_Width'(b_imm_c);
        ctrl_d    = dec_c.ctrl;
        case (dec_c.cls)
          CLS_REG, CLS_BRANCH: begin
            op1_d = rs1_data;
            op2_d = rs2_data;
          end
          CLS_IMM: begin
            op1_d = rs1_data;
            op2_d = dec_c.use_shamt ? Data_Width'(sh_imm_c) : Data_Width'(i_imm_c);
          end
          default: begin
            op1_d = '0;
            op2_d = '0;
          end
        endcase
      end
      EXEC: begin
        state_d = COMMIT;
        case (cls_q)
          CLS_REG, CLS_IMM: begin
            if (rd_c != 5'd0) begin
              rd_we_d    = 1'b1;
              rd_addr_d  = Addr_Width'(rd_c);
              rd_wdata_d = wb_flag_q ? Data_Width'(eq) : ALUout;
            end
          end
          CLS_BRANCH: begin
            br_valid_d  = 1'b1;
            br_taken_d  = (funct3_q == F3_BNE) ? !eq : eq;
            br_offset_d = br_imm_q;
          end
          default: illegal_d = 1'b1;
        endcase
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  // State and output registers; reset also kills any in-flight COMMIT strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      instr_q     <= '0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      cls_q       <= CLS_ILLEGAL;
      wb_flag_q   <= 1'b0;
      funct3_q    <= '0;
      br_imm_q    <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      ctrl_q      <= ALU_ADD;
      rd_we_q     <= 1'b0;
      rd_addr_q   <= '0;
      rd_wdata_q  <= '0;
      br_valid_q  <= 1'b0;
      br_taken_q  <= 1'b0;
      br_offset_q <= '0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      instr_q     <= instr_d;
      rs1_addr_q  <= rs1_addr_d;
      rs2_addr_q  <= rs2_addr_d;
      cls_q       <= cls_d;
      wb_flag_q   <= wb_flag_d;
      funct3_q    <= funct3_d;
      br_imm_q    <= br_imm_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      ctrl_q      <= ctrl_d;
      rd_we_q     <= rd_we_d;
      rd_addr_q   <= rd_addr_d;
      rd_wdata_q  <= rd_wdata_d;
      br_valid_q  <= br_valid_d;
      br_taken_q  <= br_taken_d;
      br_offset_q <= br_offset_d;
      illegal_q   <= illegal_d;
    end
  end

  assign instr_ready = ready_q;
  assign rs1_addr    = rs1_addr_q;
  assign rs2_addr    = rs2_addr_q;
  assign op1         = op1_q;
  assign op2         = op2_q;
  assign ALU_ctrl    = ctrl_q;
  assign rd_we       = rd_we_q;
  assign rd_addr     = rd_addr_q;
  assign rd_wdata    = rd_wdata_q;
  assign br_valid    = br_valid_q;
  assign br_taken    = br_taken_q;
  assign br_offset   = br_offset_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU, a register file
// model and a scoreboard of expected COMMIT results.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [3:0]  ALU_ctrl;
  logic [31:0] ALUout;
  logic        eq;
  logic        rd_we;
  logic [4:0]  rd_addr;
  logic [31:0] rd_wdata;
  logic        br_valid;
  logic        br_taken;
  logic [31:0] br_offset;
  logic        illegal;

  logic [31:0] regs [32];
  logic        force_en;
  logic [31:0] force_out;
  logic        force_eq;
  logic [31:0] alu_r;
  logic        alu_flag;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        bv;
    logic        bt;
    logic [31:0] boff;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  alu_sequencer #(.Data_Width(32), .Addr_Width(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .op1         (op1),
    .op2         (op2),
    .ALU_ctrl    (ALU_ctrl),
    .ALUout      (ALUout),
    .eq          (eq),
    .rd_we       (rd_we),
    .rd_addr     (rd_addr),
    .rd_wdata    (rd_wdata),
    .br_valid    (br_valid),
    .br_taken    (br_taken),
    .br_offset   (br_offset),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  assign rs1_data = regs[rs1_addr];
  assign rs2_data = regs[rs2_addr];

  // Behavioural ALU; the flag is the compare result for SLT/BGE, zero-detect otherwise.
  always_comb begin
    alu_r = 32'd0;
    case (ALU_ctrl)
      4'b0000: alu_r = op1 + op2;
      4'b0001: alu_r = op1 - op2;
      4'b0010: alu_r = op1 & op2;
      4'b0011: alu_r = op1 | op2;
      4'b0100: alu_r = op1 << op2[4:0];
      4'b0101: alu_r = {31'd0, $signed(op1) < $signed(op2)};
      4'b0110: alu_r = op1 >> op2[4:0];
      4'b0111: alu_r = 32'($signed(op1) >>> op2[4:0]);
      4'b1000: alu_r = {31'd0, $signed(op1) >= $signed(op2)};
      4'b1001: alu_r = op1 ^ op2;
      default: alu_r = 32'd0;
    endcase
    alu_flag = (ALU_ctrl == 4'b0101 || ALU_ctrl == 4'b1000) ? alu_r[0] : (alu_r == 32'd0);
    if (force_en) begin
      alu_r    = force_out;
      alu_flag = force_eq;
    end
  end

  assign ALUout = alu_r;
  assign eq     = alu_flag;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic exp_t e_wb(input logic [4:0] a, input logic [31:0] d);
    return '{we: 1'b1, addr: a, wdata: d, bv: 1'b0, bt: 1'b0, boff: 32'd0, ill: 1'b0};
  endfunction

  function automatic exp_t e_br(input logic t, input logic [31:0] off);
    return '{we: 1'b0, addr: 5'd0, wdata: 32'd0, bv: 1'b1, bt: t, boff: off, ill: 1'b0};
  endfunction

  function automatic exp_t e_none();
    return '{we: 1'b0, addr: 5'd0, wdata: 32'd0, bv: 1'b0, bt: 1'b0, boff: 32'd0, ill: 1'b0};
  endfunction

  function automatic exp_t e_ill();
    return '{we: 1'b0, addr: 5'd0, wdata: 32'd0, bv: 1'b0, bt: 1'b0, boff: 32'd0, ill: 1'b1};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " instr_ready"}, 32'(instr_ready), 32'd1);
    check({tag, " rd_we"},       32'(rd_we),       32'd0);
    check({tag, " br_valid"},    32'(br_valid),    32'd0);
    check({tag, " illegal"},     32'(illegal),     32'd0);
    check({tag, " br_taken"},    32'(br_taken),    32'd0);
    check({tag, " op1"},         op1,              32'd0);
    check({tag, " op2"},         op2,              32'd0);
    check({tag, " ALU_ctrl"},    32'(ALU_ctrl),    32'd0);
    check({tag, " rd_addr"},     32'(rd_addr),     32'd0);
    check({tag, " rd_wdata"},    rd_wdata,         32'd0);
    check({tag, " br_offset"},   br_offset,        32'd0);
    check({tag, " rs1_addr"},    32'(rs1_addr),    32'd0);
    check({tag, " rs2_addr"},    32'(rs2_addr),    32'd0);
  endtask

  // Handshake with a bounded wait for instr_ready; returns just after the accept edge.
  task automatic accept(input logic [31:0] ins, input string tag);
    int waited;
    waited      = 0;
    instr       = ins;
    instr_valid = 1'b1;
    while (!instr_ready && waited < 8) begin
      tick();
      waited++;
    end
    check({tag, " ready_seen"}, 32'(instr_ready), 32'd1);
    tick();
    instr_valid = 1'b0;
    check({tag, " ready_low"}, 32'(instr_ready), 32'd0);
  endtask

  task automatic commit_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, " sb_nonempty"}, 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    check({tag, " rd_we"},    32'(rd_we),    32'(e.we));
    check({tag, " br_valid"}, 32'(br_valid), 32'(e.bv));
    check({tag, " illegal"},  32'(illegal),  32'(e.ill));
    if (e.we) begin
      check({tag, " rd_addr"},  32'(rd_addr), 32'(e.addr));
      check({tag, " rd_wdata"}, rd_wdata,     e.wdata);
    end
    if (e.bv) begin
      check({tag, " br_taken"},  32'(br_taken), 32'(e.bt));
      check({tag, " br_offset"}, br_offset,     e.boff);
    end
  endtask

  task automatic run_one(input logic [31:0] ins, input exp_t e, input logic [3:0] c,
                         input logic [31:0] a, input logic [31:0] b, input string tag);
    sb.push_back(e);
    accept(ins, tag);
    check({tag, " rs1_addr"}, 32'(rs1_addr), 32'(ins[19:15]));
    check({tag, " rs2_addr"}, 32'(rs2_addr), 32'(ins[24:20]));
    tick();
    check({tag, " ALU_ctrl"}, 32'(ALU_ctrl), 32'(c));
    check({tag, " op1"},      op1,           a);
    check({tag, " op2"},      op2,           b);
    tick();
    commit_check(tag);
    tick();
    check({tag, " strobes_drop"}, 32'({rd_we, br_valid, illegal}), 32'd0);
    check({tag, " ready_back"},   32'(instr_ready),               32'd1);
  endtask

  logic [31:0] add_ins;
  logic [31:0] sub_ins;

  initial begin
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = 32'd0;
    force_en    = 1'b0;
    force_out   = 32'd0;
    force_eq    = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    regs[1]  = 32'd5;
    regs[2]  = 32'd7;
    regs[6]  = 32'h8000_0010;
    regs[7]  = 32'd9;
    regs[8]  = 32'd9;
    regs[10] = 32'd3;
    add_ins = enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011);
    sub_ins = enc_r(7'b0100000, 5'd1, 5'd2, 3'b000, 5'd11, 7'b0110011);

    tick();
    tick();
    check_reset_vals("reset");
    rst = 1'b0;
    tick();
    check("post_reset ready", 32'(instr_ready), 32'd1);

    run_one(add_ins, e_wb(5'd3, 32'd12), 4'b0000, 32'd5, 32'd7, "add");

    force_en  = 1'b1;
    force_out = 32'hFFFF_FFFF;
    force_eq  = 1'b1;
    run_one(enc_i(12'd10, 5'd10, 3'b010, 5'd4, 7'b0010011), e_wb(5'd4, 32'd1),
            4'b0101, 32'd3, 32'd10, "slti");
    force_en  = 1'b0;

    run_one(enc_b(13'h1FF8, 5'd8, 5'd7, 3'b000), e_br(1'b1, 32'hFFFF_FFF8),
            4'b0001, 32'd9, 32'd9, "beq");
    run_one(enc_b(13'h1FF8, 5'd8, 5'd7, 3'b001), e_br(1'b0, 32'hFFFF_FFF8),
            4'b0001, 32'd9, 32'd9, "bne");
    run_one(enc_b(13'd16, 5'd2, 5'd1, 3'b100), e_br(1'b1, 32'd16),
            4'b0101, 32'd5, 32'd7, "blt");
    run_one(enc_b(13'd16, 5'd2, 5'd1, 3'b101), e_br(1'b0, 32'd16),
            4'b1000, 32'd5, 32'd7, "bge");
    run_one(enc_i(12'd5, 5'd1, 3'b000, 5'd0, 7'b0010011), e_none(),
            4'b0000, 32'd5, 32'd5, "addi_x0");
    run_one(32'h0000_0000, e_ill(), 4'b0000, 32'd0, 32'd0, "illegal");
    run_one(enc_r(7'b0100000, 5'd4, 5'd6, 3'b101, 5'd5, 7'b0010011),
            e_wb(5'd5, 32'hF800_0001), 4'b0111, 32'h8000_0010, 32'd4, "srai");

    // Back-to-back with instr_valid held high
    sb.push_back(e_wb(5'd3, 32'd12));
    sb.push_back(e_wb(5'd11, 32'd2));
    accept(add_ins, "b2b first");
    instr_valid = 1'b1;
    instr       = sub_ins;
    tick();
    check("b2b ready_low_2", 32'(instr_ready), 32'd0);
    tick();
    check("b2b ready_low_3", 32'(instr_ready), 32'd0);
    commit_check("b2b first");
    tick();
    check("b2b ready_back", 32'(instr_ready), 32'd1);
    tick();
    check("b2b second_accept", 32'(instr_ready), 32'd0);
    instr_valid = 1'b0;
    tick();
    tick();
    commit_check("b2b second");
    tick();

    // Reset landing in EXEC abandons the instruction
    accept(add_ins, "rst_exec");
    tick();
    check("rst_exec op1_before", op1, 32'd5);
    rst = 1'b1;
    #1;
    check_reset_vals("rst_exec");
    tick();
    rst = 1'b0;
    tick();
    check("rst_exec ready_after_release", 32'(instr_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("rst_exec no_rd_we", 32'(rd_we), 32'd0);
      tick();
    end

    // Reset landing in COMMIT clears the strobe; valid in the release cycle is taken
    accept(add_ins, "rst_commit");
    tick();
    tick();
    check("rst_commit rd_we_before", 32'(rd_we), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_commit rd_we_cleared", 32'(rd_we), 32'd0);
    check("rst_commit rd_wdata_cleared", rd_wdata, 32'd0);
    instr_valid = 1'b1;
    instr       = sub_ins;
    sb.push_back(e_wb(5'd11, 32'd2));
    tick();
    rst = 1'b0;
    tick();
    check("release accept", 32'(instr_ready), 32'd0);
    instr_valid = 1'b0;
    tick();
    tick();
    commit_check("release");
    tick();

    check("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
